// File: rtl/pll_lock_div.sv
// Frequency-lock detector and word-clock divider.
// Measures the Ref_Clk period in CLK cycles, declares lock after a run of
// in-tolerance periods, and produces a divided word clock while locked.
module pll_lock_div #(
    parameter int MULT     = 50,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Ref_Clk,
    input  logic [1:0]       Width_Sel,
    output logic             Locked,
    output logic             Lock_Lost,
    output logic             Word_Clk,
    output logic [CNT_W-1:0] Period
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   MEAS_ONE = {{CNT_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    logic              refSync1_q, refSync2_q, refDly_q;
    logic              refRise;
    logic [CNT_W-1:0]  cnt_q;
    logic              cntSat;
    logic [CNT_W:0]    meas;
    logic [CNT_W-1:0]  measClamp;
    logic              measGood;
    state_t            state_q, state_d;
    logic [GOOD_W-1:0] goodCnt_q, goodCnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              locked_q, lockLost_q, wordClk_q, wordClk_d;
    logic [4:0]        divCnt_q, divCnt_d, divN_q, divN_d;

    function automatic logic [4:0] widthToN(input logic [1:0] sel);
        case (sel)
            2'b00:   return 5'd8;
            2'b01:   return 5'd10;
            2'b10:   return 5'd16;
            default: return 5'd20;
        endcase
    endfunction

    assign refRise   = refSync2_q & ~refDly_q;
    assign cntSat    = (cnt_q == CNT_MAX);
    assign meas      = {1'b0, cnt_q} + MEAS_ONE;
    assign measClamp = meas[CNT_W] ? CNT_MAX : meas[CNT_W-1:0];

    // Synchronise Ref_Clk, keep a delayed copy for edge detection, and run the saturating period counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            refSync1_q <= 1'b0;
            refSync2_q <= 1'b0;
            refDly_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            refSync1_q <= Ref_Clk;
            refSync2_q <= refSync1_q;
            refDly_q   <= refSync2_q;
            if (refRise) begin
                cnt_q <= '0;
            end else if (!cntSat) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    // Tolerance test done in signed arithmetic so a short period cannot wrap into a false pass.
    always_comb begin
        int measInt;
        measInt = int'(meas);
        if (measInt >= MULT) begin
            measGood = (measInt - MULT) <= TOL;
        end else begin
            measGood = (MULT - measInt) <= TOL;
        end
    end

    // Lock state machine next state; a reference edge always wins over a coinciding saturation.
    always_comb begin
        int goodNext;
        state_d   = state_q;
        goodCnt_d = goodCnt_q;
        period_d  = period_q;
        goodNext  = int'(goodCnt_q) + 1;
        if (refRise) begin
            case (state_q)
                IDLE: begin
                    state_d   = ACQ;
                    goodCnt_d = '0;
                end
                ACQ: begin
                    period_d = measClamp;
                    if (measGood) begin
                        goodCnt_d = GOOD_W'(goodNext);
                        if (goodNext >= LOCK_CNT) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        goodCnt_d = '0;
                    end
                end
                default: begin
                    period_d = measClamp;
                    if (!measGood) begin
                        state_d   = ACQ;
                        goodCnt_d = '0;
                    end
                end
            endcase
        end else if (cntSat) begin
            state_d   = IDLE;
            goodCnt_d = '0;
        end
    end

    // Word-clock divider; restarts at zero on lock entry and only picks up a new ratio at wrap.
    always_comb begin
        divN_d = divN_q;
        if (state_d != LOCKED || state_q != LOCKED) begin
            divCnt_d = '0;
        end else if (divCnt_q == divN_q - 5'd1) begin
            divCnt_d = '0;
            divN_d   = widthToN(Width_Sel);
        end else begin
            divCnt_d = divCnt_q + 5'd1;
        end
        wordClk_d = (state_d == LOCKED) && (divCnt_d < (divN_d >> 1));
    end

    // State register with registered Locked, Lock_Lost and Word_Clk derived from the next state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            goodCnt_q  <= '0;
            period_q   <= '0;
            locked_q   <= 1'b0;
            lockLost_q <= 1'b0;
            wordClk_q  <= 1'b0;
            divCnt_q   <= '0;
            divN_q     <= 5'd8;
        end else begin
            state_q    <= state_d;
            goodCnt_q  <= goodCnt_d;
            period_q   <= period_d;
            locked_q   <= (state_d == LOCKED);
            lockLost_q <= (state_q == LOCKED) && (state_d != LOCKED);
            wordClk_q  <= wordClk_d;
            divCnt_q   <= divCnt_d;
            divN_q     <= divN_d;
        end
    end

    assign Locked    = locked_q;
    assign Lock_Lost = lockLost_q;
    assign Word_Clk  = wordClk_q;
    assign Period    = period_q;

endmodule

// File: tb/tb_pll_lock_div.sv
// Testbench for pll_lock_div: vector table, corner sequences and a randomized
// run checked against a per-reference-edge behavioural model.
module tb_pll_lock_div;

    localparam int MULT     = 50;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 4;
    localparam int CNT_W    = 8;

    logic             CLK;
    logic             RST;
    logic             Ref_Clk;
    logic [1:0]       Width_Sel;
    logic             Locked;
    logic             Lock_Lost;
    logic             Word_Clk;
    logic [CNT_W-1:0] Period;

    pll_lock_div #(
        .MULT(MULT), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST), .Ref_Clk(Ref_Clk), .Width_Sel(Width_Sel),
        .Locked(Locked), .Lock_Lost(Lock_Lost), .Word_Clk(Word_Clk), .Period(Period)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state, advanced once per generated reference rising edge
    bit mIdle    = 1'b1;
    bit mLocked  = 1'b0;
    int mStreak  = 0;
    int mPeriod  = 0;
    int mPrevLen = 0;
    int mLost    = 0;

    // Monitor state
    int  lostSeen  = 0;
    int  lastHigh  = 0;
    int  lastLow   = 0;
    int  hiRun     = 0;
    int  loRun     = 0;
    int  wcN       = 8;
    int  wcP       = 0;
    bit  wasLocked = 1'b0;

    typedef struct {
        bit         doRst;
        int         len;
        logic [1:0] ws;
        bit         expLocked;
        int         expPeriod;
    } vec_t;

    vec_t vecs[$];

    function automatic int nOf(input logic [1:0] sel);
        case (sel)
            2'b00:   return 8;
            2'b01:   return 10;
            2'b10:   return 16;
            default: return 20;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelRise(input int len);
        int  meas;
        bit  good;
        if (mIdle) begin
            mIdle   = 1'b0;
            mStreak = 0;
        end else begin
            meas    = mPrevLen;
            mPeriod = (meas > 255) ? 255 : meas;
            good    = (meas >= MULT - TOL) && (meas <= MULT + TOL);
            mStreak = good ? mStreak + 1 : 0;
            if (mLocked && !good) begin
                mLocked = 1'b0;
                mLost++;
            end else if (!mLocked && mStreak >= LOCK_CNT) begin
                mLocked = 1'b1;
            end
        end
        mPrevLen = len;
    endtask

    // One reference period of len CLK cycles, rising at the first negedge
    task automatic applyStimulus(input int len, input logic [1:0] ws);
        @(negedge CLK);
        Width_Sel = ws;
        Ref_Clk   = 1'b1;
        modelRise(len);
        repeat (len / 2) @(negedge CLK);
        Ref_Clk = 1'b0;
        repeat (len - len / 2 - 1) @(negedge CLK);
    endtask

    task automatic holdLow(input int n);
        repeat (n) @(negedge CLK);
        mPrevLen += n;
        if (mPrevLen > 256 && !mIdle) begin
            if (mLocked) mLost++;
            mLocked = 1'b0;
            mIdle   = 1'b1;
            mStreak = 0;
        end
    endtask

    task automatic modelReset();
        mIdle    = 1'b1;
        mLocked  = 1'b0;
        mStreak  = 0;
        mPeriod  = 0;
        mPrevLen = 0;
    endtask

    task automatic doReset();
        @(negedge CLK);
        RST     = 1'b0;
        Ref_Clk = 1'b0;
        modelReset();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
    endtask

    // Per-cycle monitor: Lock_Lost pulse rule, Word_Clk waveform, run lengths
    always @(posedge CLK) begin
        #1;
        if (!RST) begin
            wcN       = 8;
            wcP       = 0;
            wasLocked = 1'b0;
            hiRun     = 0;
            loRun     = 0;
        end else begin
            checkOutput("Lock_Lost_rule", int'(Lock_Lost), int'(wasLocked && !Locked));
            if (Lock_Lost) lostSeen++;
            if (Locked) begin
                if (!wasLocked) begin
                    wcP = 0;
                end else if (wcP == wcN - 1) begin
                    wcP = 0;
                    wcN = nOf(Width_Sel);
                end else begin
                    wcP++;
                end
                checkOutput("Word_Clk_locked", int'(Word_Clk), int'(wcP < wcN / 2));
            end else begin
                checkOutput("Word_Clk_unlocked", int'(Word_Clk), 0);
            end
            if (Word_Clk) begin
                if (loRun > 0) lastLow = loRun;
                loRun = 0;
                hiRun++;
            end else begin
                if (hiRun > 0) lastHigh = hiRun;
                hiRun = 0;
                loRun++;
            end
            wasLocked = Locked;
        end
    end

    initial begin
        int lost0;
        int len;
        logic [1:0] ws;

        RST       = 1'b0;
        Ref_Clk   = 1'b0;
        Width_Sel = 2'b00;
        repeat (3) @(negedge CLK);
        checkOutput("reset_Locked", int'(Locked), 0);
        checkOutput("reset_Lock_Lost", int'(Lock_Lost), 0);
        checkOutput("reset_Word_Clk", int'(Word_Clk), 0);
        checkOutput("reset_Period", int'(Period), 0);
        RST = 1'b1;

        // Nominal lock, then a bad period drops it
        vecs.push_back('{1'b1, 50, 2'd0, 1'b0, 0});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b0, 50});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b0, 50});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b0, 50});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b1, 50});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b1, 50});
        vecs.push_back('{1'b0, 53, 2'd0, 1'b1, 50});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b0, 53});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b0, 50});
        // Tolerance edges 49/51
        vecs.push_back('{1'b1, 49, 2'd0, 1'b0, 0});
        vecs.push_back('{1'b0, 51, 2'd0, 1'b0, 49});
        vecs.push_back('{1'b0, 49, 2'd0, 1'b0, 51});
        vecs.push_back('{1'b0, 51, 2'd0, 1'b0, 49});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b1, 51});
        // Off-frequency reference never locks
        vecs.push_back('{1'b1, 53, 2'd0, 1'b0, 0});
        vecs.push_back('{1'b0, 53, 2'd0, 1'b0, 53});
        vecs.push_back('{1'b0, 53, 2'd0, 1'b0, 53});
        vecs.push_back('{1'b0, 53, 2'd0, 1'b0, 53});
        vecs.push_back('{1'b0, 53, 2'd0, 1'b0, 53});
        vecs.push_back('{1'b0, 53, 2'd0, 1'b0, 53});
        // Bad period in acquisition restarts the count
        vecs.push_back('{1'b1, 50, 2'd0, 1'b0, 0});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b0, 50});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b0, 50});
        vecs.push_back('{1'b0, 53, 2'd0, 1'b0, 50});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b0, 53});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b0, 50});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b0, 50});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b0, 50});
        vecs.push_back('{1'b0, 50, 2'd0, 1'b1, 50});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].doRst) doReset();
            applyStimulus(vecs[i].len, vecs[i].ws);
            checkOutput($sformatf("vec%0d_Locked", i), int'(Locked), int'(vecs[i].expLocked));
            checkOutput($sformatf("vec%0d_Period", i), int'(Period), vecs[i].expPeriod);
        end

        // Word clock 4/4 at ratio 8, then 10/10 after switching to ratio 20
        applyStimulus(50, 2'd0);
        applyStimulus(50, 2'd0);
        checkOutput("wc8_high", lastHigh, 4);
        checkOutput("wc8_low", lastLow, 4);
        applyStimulus(50, 2'd3);
        applyStimulus(50, 2'd3);
        applyStimulus(50, 2'd3);
        checkOutput("wc20_high", lastHigh, 10);
        checkOutput("wc20_low", lastLow, 10);
        checkOutput("wc20_Locked", int'(Locked), 1);

        // Reference lost while locked: saturation drops lock once and returns to IDLE
        applyStimulus(50, 2'd0);
        lost0 = lostSeen;
        holdLow(300);
        checkOutput("sat_Locked", int'(Locked), 0);
        checkOutput("sat_Word_Clk", int'(Word_Clk), 0);
        checkOutput("sat_Period_hold", int'(Period), 50);
        checkOutput("sat_lost_pulses", lostSeen - lost0, 1);
        applyStimulus(60, 2'd0);
        checkOutput("idle_first_edge_Period", int'(Period), 50);
        applyStimulus(50, 2'd0);
        checkOutput("acq_Period", int'(Period), 60);
        checkOutput("acq_Locked", int'(Locked), 0);

        // Reset in the middle of lock, then relock with exact timing
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(50, 2'd0);
        checkOutput("prereset_Locked", int'(Locked), 1);
        lost0 = lostSeen;
        @(negedge CLK);
        #2 RST = 1'b0;
        modelReset();
        #1;
        checkOutput("midreset_Locked", int'(Locked), 0);
        checkOutput("midreset_Word_Clk", int'(Word_Clk), 0);
        checkOutput("midreset_Lock_Lost", int'(Lock_Lost), 0);
        checkOutput("midreset_Period", int'(Period), 0);
        Ref_Clk = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        checkOutput("midreset_no_pulse", lostSeen - lost0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(50, 2'd0);
        checkOutput("relock_before5", int'(Locked), 0);
        @(negedge CLK);
        Ref_Clk = 1'b1;
        modelRise(50);
        @(posedge CLK); #1;
        checkOutput("relock_e1", int'(Locked), 0);
        @(posedge CLK); #1;
        checkOutput("relock_e2", int'(Locked), 0);
        @(posedge CLK); #1;
        checkOutput("relock_e3_Locked", int'(Locked), 1);
        checkOutput("relock_e3_Word_Clk", int'(Word_Clk), 1);
        checkOutput("relock_Period", int'(Period), 50);
        @(negedge CLK);
        repeat (22) @(negedge CLK);
        Ref_Clk = 1'b0;
        repeat (24) @(negedge CLK);

        // Randomized periods and ratios against the model
        for (int i = 0; i < 80; i++) begin
            len = ($urandom_range(0, 4) != 0) ? int'($urandom_range(49, 51)) : int'($urandom_range(44, 56));
            ws  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : Width_Sel;
            applyStimulus(len, ws);
            checkOutput($sformatf("rnd%0d_Locked", i), int'(Locked), int'(mLocked));
            checkOutput($sformatf("rnd%0d_Period", i), int'(Period), mPeriod);
        end
        checkOutput("rnd_lost_count", lostSeen, mLost);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pll_lock_div.md
PLL_LOCK_DIV -- requirements
Module: pll_lock_div

Interface
REQ-001 SHALL have parameter MULT, default 50: expected CLK cycles per Ref_Clk period.
REQ-002 SHALL have parameter TOL, default 1: allowed absolute deviation of a measured period from MULT.
REQ-003 SHALL have parameter LOCK_CNT, default 4: consecutive in-tolerance periods required for lock.
REQ-004 SHALL have parameter CNT_W, default 8: period counter width.
REQ-005 SHALL have port CLK, input, 1: the single clock (fast bit clock); all flops SHALL use its rising edge.
REQ-006 SHALL have port RST, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port Ref_Clk, input, 1: reference clock, asynchronous to CLK, sampled as data only.
REQ-008 SHALL have port Width_Sel, input, 2: word-clock divide ratio N (00=8, 01=10, 10=16, 11=20).
REQ-009 SHALL have port Locked, output, 1: frequency-lock indicator.
REQ-010 SHALL have port Lock_Lost, output, 1: one-cycle pulse on loss of lock.
REQ-011 SHALL have port Word_Clk, output, 1: CLK divided by N, active only while locked.
REQ-012 SHALL have port Period, output, CNT_W: last measured Ref_Clk period in CLK cycles.

Function
REQ-013 SHALL pass Ref_Clk through a 2-flop synchroniser plus one delay flop; ref_rise = sync2 & ~delay.
REQ-014 SHALL run period counter cnt: cleared to 0 on ref_rise, else +1 per CLK, saturating at 2^CNT_W-1.
REQ-015 SHALL define measurement meas = cnt+1 on ref_rise, i.e. CLK cycles between consecutive ref_rise pulses.
REQ-016 SHALL use states IDLE, ACQ, LOCKED; reset state is IDLE.
REQ-017 IDLE: on first ref_rise SHALL clear cnt and go to ACQ; Period not updated.
REQ-018 ACQ: on each ref_rise SHALL load Period <= meas; good if |meas-MULT| <= TOL (unsigned-safe compare); good -> good_cnt+1, bad -> good_cnt=0.
REQ-019 ACQ: when good_cnt reaches LOCK_CNT SHALL go to LOCKED; Locked = 1 from the cycle after that ref_rise.
REQ-020 LOCKED: ref_rise with bad meas SHALL go to ACQ with good_cnt=0; Period updated.
REQ-021 Any state: cnt reaching saturation (reference lost) SHALL go to IDLE with good_cnt=0; Period holds.
REQ-022 Lock_Lost SHALL pulse high exactly one cycle on each LOCKED exit, same cycle Locked falls.
REQ-023 Locked SHALL be a registered decode of state == LOCKED.
REQ-024 Word_Clk divider SHALL count 0..N-1 only while LOCKED; Word_Clk = 1 for counts 0..N/2-1, 0 otherwise.
REQ-025 Divider SHALL start at count 0 in the first LOCKED cycle; first Word_Clk high coincides with Locked rising.
REQ-026 Width_Sel change SHALL take effect only at divider wrap (count N-1 -> 0); N latched at wrap.
REQ-027 On leaving LOCKED, divider SHALL clear and Word_Clk SHALL be 0 in the same cycle Locked falls.
REQ-028 ref_rise coinciding with saturation SHALL be treated as a measurement (REQ-018/020), not a loss.

Reset
REQ-029 RST low SHALL immediately force: state IDLE, cnt 0, good_cnt 0, Period 0, Locked 0, Lock_Lost 0, Word_Clk 0, sync flops 0, latched N = 8.
REQ-030 Reset mid-lock SHALL drop Locked and Word_Clk with no Lock_Lost pulse; release SHALL restart from IDLE.

Verification
REQ-031 Ref period 50 CLK, Width_Sel=00 -> Locked rises the cycle after 5th ref_rise; Period=50; Word_Clk 4 high/4 low.
REQ-032 Ref period 53 -> Locked stays 0 indefinitely; Period=53.
REQ-033 Periods 49,51,49,51 after first edge -> lock; sequence 50,50,53,50 -> good_cnt resets, lock delayed by 3 further good periods.
REQ-034 Locked, Ref_Clk held low -> cnt saturates at 255, one Lock_Lost pulse, Locked=0, Word_Clk=0, state IDLE.
REQ-035 Locked, Width_Sel 00->11 mid-period -> current 8-cycle period completes, next periods 20 cycles, 10 high.
REQ-036 RST low while locked -> all outputs 0 asynchronously, no Lock_Lost; relock follows REQ-031 timing after release.
